// File: rtl/pipo_4bit.sv
// pipo_4bit: parallel-in/parallel-out storage register with load enable.
// A whole word is captured from d_in in one cycle and presented on q_out.
// valid marks that at least one load has completed since the last reset.
//
// Interface timing: there is no handshake. load acts as a plain
// per-cycle enable sampled at the clk rising edge, with no back-pressure.
// Both outputs come straight from flops, so there is no input-to-output
// combinational path.
module pipo_4bit #(
  parameter int unsigned          WIDTH     = 4,
  parameter logic [WIDTH-1:0]     RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out,
  output logic             valid
);

  // Storage word and loaded flag. Reset has priority over load, and all
  // bits are written together whenever load is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_out <= RESET_VAL;
      valid <= 1'b0;
    end else if (load) begin
      q_out <= d_in;
      valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipo_4bit.sv
// tb_pipo_4bit: directed-vector bench for pipo_4bit (WIDTH=4, RESET_VAL=0).
// Inputs change on the falling edge. Outputs are sampled 1 ns after the
// rising edge.
module tb_pipo_4bit;

  logic       clk;
  logic       reset;
  logic       load;
  logic [3:0] d_in;
  logic [3:0] q_out;
  logic       valid;

  int n_vec;
  int n_err;

  pipo_4bit #(
    .WIDTH     (4),
    .RESET_VAL (4'b0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .d_in  (d_in),
    .q_out (q_out),
    .valid (valid)
  );

  // Clock: 10 ns period, rising edges at 5, 15, 25 ns ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts one comparison and reports a miscompare.
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", tag, obs, exp);
    end
  endtask

  // Drives one set of inputs on the falling edge, then waits past the next rising edge.
  task automatic step(input logic r, input logic l, input logic [3:0] d);
    @(negedge clk);
    reset = r;
    load  = l;
    d_in  = d;
    @(posedge clk);
    #1;
  endtask

  // Checks q_out and valid against hand-computed values.
  task automatic expect_out(input string tag, input logic [3:0] q_exp, input logic v_exp);
    check({tag, "_q"}, {4'b0, q_out}, {4'b0, q_exp});
    check({tag, "_v"}, {7'b0, valid}, {7'b0, v_exp});
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    load  = 1'b0;
    d_in  = 4'b0000;

    // Reset.
    step(1'b1, 1'b0, 4'b0000);
    expect_out("reset", 4'b0000, 1'b0);

    // Load and hold.
    step(1'b0, 1'b1, 4'b1010);
    expect_out("load_1010", 4'b1010, 1'b1);
    step(1'b0, 1'b0, 4'b1111);
    expect_out("hold_1010", 4'b1010, 1'b1);

    // Reload.
    step(1'b0, 1'b1, 4'b1111);
    expect_out("reload_1111", 4'b1111, 1'b1);

    // Reset beats load, then no dead cycle after the release.
    step(1'b1, 1'b1, 4'b1111);
    expect_out("reset_wins", 4'b0000, 1'b0);
    step(1'b0, 1'b1, 4'b1111);
    expect_out("release_load", 4'b1111, 1'b1);

    // Back-to-back loads track d_in with a one-cycle lag.
    step(1'b0, 1'b1, 4'b0001);
    expect_out("b2b_0001", 4'b0001, 1'b1);
    step(1'b0, 1'b1, 4'b0101);
    expect_out("b2b_0101", 4'b0101, 1'b1);
    step(1'b0, 1'b1, 4'b1110);
    expect_out("b2b_1110", 4'b1110, 1'b1);

    // No false capture: d_in toggles across several edges with load low.
    step(1'b0, 1'b0, 4'b0000);
    expect_out("nocap_0000", 4'b1110, 1'b1);
    #2 d_in = 4'b1011;
    #1 check("nocap_mid_q", {4'b0, q_out}, 8'b0000_1110);
    step(1'b0, 1'b0, 4'b1111);
    expect_out("nocap_1111", 4'b1110, 1'b1);
    step(1'b0, 1'b0, 4'b0011);
    expect_out("nocap_0011", 4'b1110, 1'b1);

    // Outputs do not react between edges even with load high.
    @(negedge clk);
    load = 1'b1;
    d_in = 4'b0110;
    #1 check("no_comb_path_q", {4'b0, q_out}, 8'b0000_1110);
    @(posedge clk);
    #1;
    expect_out("load_0110", 4'b0110, 1'b1);

    // Reset in the middle of a hold drops the word until the next load.
    step(1'b1, 1'b0, 4'b0110);
    expect_out("mid_reset", 4'b0000, 1'b0);
    step(1'b0, 1'b0, 4'b1010);
    expect_out("after_reset_hold", 4'b0000, 1'b0);
    step(1'b0, 1'b1, 4'b1001);
    expect_out("after_reset_load", 4'b1001, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
